// File: rtl/vga_stream_out.sv
// rtl/vga_stream_out.sv - pixel-clock VGA output stage fed by a valid/ready RGB stream
//
// Purpose:
//   Owns the horizontal/vertical raster counters and pulls exactly one pixel
//   from the upstream stream for every visible position, in raster order.
//   All VGA pins are registered, so they reflect the counters one clock later.
//   A visible slot with no valid pixel is shown black, skipped, and recorded
//   in a sticky underflow flag. Timing never stretches.
//
// Ports:
//   clk        in   pixel clock
//   rst        in   asynchronous reset, active-high
//   s_valid    in   input pixel valid
//   s_ready    out  stage accepts a pixel this cycle (visible and out of reset)
//   s_red/grn/blu   in   input colour channels
//   vga_red/grn/blu out  registered colour channels
//   vga_hsync  out  registered horizontal sync
//   vga_vsync  out  registered vertical sync
//   underflow  out  sticky flag: a visible slot arrived with s_valid low

module vga_stream_out #(
    parameter int COLOR_WIDTH = 4,
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter bit H_SYNC_POL  = 1'b0,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit V_SYNC_POL  = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [COLOR_WIDTH-1:0] s_red,
    input  logic [COLOR_WIDTH-1:0] s_grn,
    input  logic [COLOR_WIDTH-1:0] s_blu,
    output logic [COLOR_WIDTH-1:0] vga_red,
    output logic [COLOR_WIDTH-1:0] vga_grn,
    output logic [COLOR_WIDTH-1:0] vga_blu,
    output logic                   vga_hsync,
    output logic                   vga_vsync,
    output logic                   underflow
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
    localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);

    // Sync window bounds are held one bit wider than the counters: with a
    // zero back porch the end of the sync window equals TOTAL, which would
    // not fit in the counter width.
    localparam logic [HW:0] H_SYNC_START = (HW+1)'(H_VISIBLE + H_FRONT);
    localparam logic [HW:0] H_SYNC_END   = (HW+1)'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW:0] V_SYNC_START = (VW+1)'(V_VISIBLE + V_FRONT);
    localparam logic [VW:0] V_SYNC_END   = (VW+1)'(V_VISIBLE + V_FRONT + V_SYNC);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [HW-1:0]          h_cnt_q, h_cnt_d;
    logic [VW-1:0]          v_cnt_q, v_cnt_d;
    logic [COLOR_WIDTH-1:0] red_q, red_d;
    logic [COLOR_WIDTH-1:0] grn_q, grn_d;
    logic [COLOR_WIDTH-1:0] blu_q, blu_d;
    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic                   underflow_q, underflow_d;

    // ------------------------------------------------------------------
    // Raster decode, all from registered counters so the ready path never
    // depends on s_valid.
    // ------------------------------------------------------------------
    logic          h_last;
    logic          v_last;
    logic          visible;
    logic          accept;
    logic          starve;
    logic          h_in_sync;
    logic          v_in_sync;
    logic [HW:0]   h_ext;
    logic [VW:0]   v_ext;

    assign h_last    = (h_cnt_q == H_LAST);
    assign v_last    = (v_cnt_q == V_LAST);
    assign visible   = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign h_ext     = {1'b0, h_cnt_q};
    assign v_ext     = {1'b0, v_cnt_q};
    assign h_in_sync = (h_ext >= H_SYNC_START) && (h_ext < H_SYNC_END);
    assign v_in_sync = (v_ext >= V_SYNC_START) && (v_ext < V_SYNC_END);

    // Pixel is consumed only in visible slots; blanking leaves s_valid
    // untouched so the upstream keeps its next pixel for the next line.
    assign accept    = visible && s_valid;
    assign starve    = visible && !s_valid;

    // While rst is held the counters sit at (0,0), which decodes as visible;
    // gate ready so nothing is consumed during reset.
    assign s_ready   = visible && !rst;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            h_cnt_d = '0;
            if (v_last) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + VW'(1);
            end
        end else begin
            h_cnt_d = h_cnt_q + HW'(1);
        end
    end

    always_comb begin
        red_d = '0;
        grn_d = '0;
        blu_d = '0;
        if (accept) begin
            red_d = s_red;
            grn_d = s_grn;
            blu_d = s_blu;
        end
        hsync_d     = h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d     = v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
        underflow_d = underflow_q || starve;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            red_q       <= '0;
            grn_q       <= '0;
            blu_q       <= '0;
            hsync_q     <= ~H_SYNC_POL;
            vsync_q     <= ~V_SYNC_POL;
            underflow_q <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            red_q       <= red_d;
            grn_q       <= grn_d;
            blu_q       <= blu_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            underflow_q <= underflow_d;
        end
    end

    assign vga_red   = red_q;
    assign vga_grn   = grn_q;
    assign vga_blu   = blu_q;
    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_stream_out.sv
// tb/tb_vga_stream_out.sv - scoreboard bench for vga_stream_out on a small 8x6 raster
module tb_vga_stream_out;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [3:0] s_red = '0, s_grn = '0, s_blu = '0;
    logic [3:0] vga_red, vga_grn, vga_blu;
    logic       vga_hsync, vga_vsync, underflow;

    always #5 clk = ~clk;

    vga_stream_out #(
        .COLOR_WIDTH(4),
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1), .H_SYNC_POL(1'b0),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .V_SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_red(s_red), .s_grn(s_grn), .s_blu(s_blu),
        .vga_red(vga_red), .vga_grn(vga_grn), .vga_blu(vga_blu),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .underflow(underflow)
    );

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
        logic       uf;
    } out_t;

    localparam out_t RST_OUT = '{r: 4'h0, g: 4'h0, b: 4'h0, hs: 1'b1, vs: 1'b1, uf: 1'b0};

    out_t oq[$];
    bit   rq[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor-side running counts; main only reads them.
    int hs_total = 0;
    int hsync_low_total = 0;
    int vsync_low_total = 0;

    // Bench raster model
    int   hm = 0, vm = 0;
    bit   uf_m = 0;
    int   cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t (model h=%0d v=%0d)",
                     name, act, exp, $time, hm, vm);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        out_t e;
        bit   r;
        if (rq.size() > 0) begin
            r = rq.pop_front();
            check("s_ready", int'(s_ready), int'(r));
        end
        if (oq.size() > 0) begin
            e = oq.pop_front();
            check("vga_red",   int'(vga_red),   int'(e.r));
            check("vga_grn",   int'(vga_grn),   int'(e.g));
            check("vga_blu",   int'(vga_blu),   int'(e.b));
            check("vga_hsync", int'(vga_hsync), int'(e.hs));
            check("vga_vsync", int'(vga_vsync), int'(e.vs));
            check("underflow", int'(underflow), int'(e.uf));
        end
        if (s_valid && s_ready) hs_total++;
        if (!vga_hsync) hsync_low_total++;
        if (!vga_vsync) vsync_low_total++;
    end

    // One pixel clock of stimulus; pushes the expected response.
    task automatic step(input bit r, input bit v, input logic [3:0] rr, input logic [3:0] gg,
                        input logic [3:0] bb);
        out_t e;
        bit   vis;
        rst     = r;
        s_valid = v;
        s_red   = rr;
        s_grn   = gg;
        s_blu   = bb;
        if (r) begin
            hm = 0; vm = 0; uf_m = 0;
            rq.push_back(1'b0);
            // Async reset: outputs are already at reset values this cycle.
            oq.delete();
            oq.push_back(RST_OUT);
            oq.push_back(RST_OUT);
        end else begin
            vis = (hm < 4) && (vm < 3);
            rq.push_back(vis);
            if (vis && !v) uf_m = 1;
            e.r  = (vis && v) ? rr : 4'h0;
            e.g  = (vis && v) ? gg : 4'h0;
            e.b  = (vis && v) ? bb : 4'h0;
            e.hs = !(hm == 5 || hm == 6);
            e.vs = !(vm == 4);
            e.uf = uf_m;
            oq.push_back(e);
            if (hm == 7) begin
                hm = 0;
                vm = (vm == 5) ? 0 : vm + 1;
            end else begin
                hm = hm + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic count_step(input bit v, input bit fill_blank);
        logic [3:0] c;
        bit         vis;
        vis = (hm < 4) && (vm < 3);
        c   = cnt[3:0];
        if (fill_blank && !vis) step(1'b0, v, 4'hF, 4'hF, 4'hF);
        else                    step(1'b0, v, c, c + 4'd1, c + 4'd2);
        cnt++;
    endtask

    // mode 0: all valid; 1: drop pixel (2,1); 2: F/F/F during blanking
    task automatic run_frame(input int mode, input string tag);
        int hs0, hl0, vl0;
        bit v;
        hs0 = hs_total; hl0 = hsync_low_total; vl0 = vsync_low_total;
        for (int i = 0; i < 48; i++) begin
            v = !(mode == 1 && hm == 2 && vm == 1);
            count_step(v, mode == 2);
        end
        check({tag, "_handshakes"}, hs_total - hs0, (mode == 1) ? 11 : 12);
        check({tag, "_hsync_low"}, hsync_low_total - hl0, 12);
        check({tag, "_vsync_low"}, vsync_low_total - vl0, 8);
        check({tag, "_frame_wrap"}, hm * 8 + vm, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'h7, 4'h7, 4'h7);
        check("reset_hsync", int'(vga_hsync), 1);
        check("reset_ready", int'(s_ready), 0);
        run_frame(0, "f0");
        run_frame(0, "f1");
        run_frame(1, "drop");
        check("underflow_sticky", int'(underflow), 1);
        run_frame(2, "blank_fill");
        // Run to pixel (3,2) then hold reset for two clocks.
        for (int i = 0; i < 48 && !(hm == 3 && vm == 2); i++) count_step(1'b1, 1'b0);
        step(1'b1, 1'b1, 4'h5, 4'h5, 4'h5);
        check("midreset_underflow", int'(underflow), 0);
        step(1'b1, 1'b1, 4'h5, 4'h5, 4'h5);
        run_frame(0, "post_reset");
        @(negedge clk); #1;
        check("queue_drained", oq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
